// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: controller state encoding,
// datapath control bundle and the default operand width.
package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_X = 3'd1;
  localparam logic [2:0] ST_LOAD_Y = 3'd2;
  localparam logic [2:0] ST_CALC   = 3'd3;
  localparam logic [2:0] ST_OUT_Q  = 3'd4;
  localparam logic [2:0] ST_OUT_R  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_X = ST_LOAD_X,
    LOAD_Y = ST_LOAD_Y,
    CALC   = ST_CALC,
    OUT_Q  = ST_OUT_Q,
    OUT_R  = ST_OUT_R
  } stateT;

  // Control strobes from the controller to the shift/subtract datapath.
  typedef struct packed {
    logic ldQ;    // Q <= inBus (dividend)
    logic ldM;    // M <= inBus (divisor)
    logic initA;  // A <= 0
    logic shift;  // perform one shift/subtract iteration
    logic load;   // iteration result: take the difference, quotient bit = 1
    logic selQ;   // drive Q onto outBus
    logic selR;   // drive remainder onto outBus
  } ctrlT;

endpackage

// File: rtl/divider_datapath.sv
// Shift/subtract datapath: A/Q/M registers, trial subtractor and result mux.
// Returns the trial-difference sign bit so the controller can decide each bit.
module divider_datapath
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  ctrlT             ctrl,
  input  logic [WIDTH-1:0] inBus,
  output logic             signBit,
  output logic [WIDTH-1:0] outBus
);

  logic [WIDTH:0]   aReg;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] mReg;

  logic [2*WIDTH:0] aqShifted;
  logic [WIDTH:0]   aShifted;
  logic [WIDTH-1:0] qShifted;
  logic [WIDTH:0]   trial;

  // The combined {A,Q} shift drops A's top bit; it is always 0 because the
  // partial remainder never reaches M.
  assign aqShifted = {aReg, qReg} << 1;
  assign aShifted  = aqShifted[2*WIDTH:WIDTH];
  assign qShifted  = aqShifted[WIDTH-1:0];
  assign trial     = aShifted - {1'b0, mReg};
  assign signBit   = trial[WIDTH];

  // NOTE: every state element uses non-blocking assignment so all registers
  // update together from values sampled at the same clock edge.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset along with the FSM so outputs and
    // stale operands are deterministic after any reset, including mid-CALC.
    if (rst) begin
      aReg <= '0;
      qReg <= '0;
      mReg <= '0;
    end else begin
      if (ctrl.initA) aReg <= '0;
      if (ctrl.ldQ)   qReg <= inBus;
      if (ctrl.ldM)   mReg <= inBus;
      if (ctrl.shift) begin
        aReg <= ctrl.load ? trial : aShifted;
        qReg <= {qShifted[WIDTH-1:1], ctrl.load};
      end
    end
  end

  // NOTE: a default is assigned first so no path leaves outBus unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    outBus = '0;
    if (ctrl.selQ)      outBus = qReg;
    else if (ctrl.selR) outBus = aReg[WIDTH-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned sequential restoring divider: controller FSM and iteration counter
// driving divider_datapath; operands arrive and results leave over narrow buses.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  input  logic [WIDTH-1:0] inBus,
  output logic [WIDTH-1:0] outBus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  stateT         state;
  stateT         nextState;
  logic [CW-1:0] cnt;
  ctrlT          ctrl;
  logic          signBit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (state == LOAD_Y)    cnt <= '0;
      else if (state == CALC) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    ctrl      = '0;
    unique case (state)
      IDLE:   if (start) nextState = LOAD_X;
      LOAD_X: begin
        ctrl.ldQ   = 1'b1;
        ctrl.initA = 1'b1;
        nextState  = LOAD_Y;
      end
      LOAD_Y: begin
        ctrl.ldM  = 1'b1;
        nextState = CALC;
      end
      CALC: begin
        // A non-negative trial difference means the divisor fits: keep it.
        ctrl.shift = 1'b1;
        ctrl.load  = ~signBit;
        if (cnt == CNT_LAST) nextState = OUT_Q;
      end
      OUT_Q: begin
        ctrl.selQ = 1'b1;
        nextState = OUT_R;
      end
      OUT_R: begin
        ctrl.selR = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // done and outBus depend only on the state register and datapath registers.
  assign done = ctrl.selQ | ctrl.selR;

  divider_datapath #(
    .WIDTH(WIDTH)
  ) uDatapath (
    .clk    (clk),
    .rst    (rst),
    .ctrl   (ctrl),
    .inBus  (inBus),
    .signBit(signBit),
    .outBus (outBus)
  );

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: arithmetic reference model with a
// per-cycle output compare, plus directed vectors with literal expectations.
module tb_restoring_divider;

  localparam int W   = 6;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic [W-1:0] inBus;
  logic [W-1:0] outBus;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .done  (done),
    .inBus (inBus),
    .outBus(outBus)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: k counts cycles since start was accepted (0 = idle).
  // Results come straight from integer division with the divide-by-zero rule.
  int         k = 0;
  logic [W-1:0] mX, mQ, mR;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
    end else if (k == 0) begin
      if (start) k <= 1;
    end else begin
      if (k == 1) mX <= inBus;
      if (k == 2) begin
        mQ <= (inBus == 0) ? {W{1'b1}} : mX / inBus;
        mR <= (inBus == 0) ? mX : mX % inBus;
      end
      k <= (k == LAT + 1) ? 0 : k + 1;
    end
  end

  always @(negedge clk) begin
    logic         expDone;
    logic [W-1:0] expBus;
    expDone = (k == LAT) || (k == LAT + 1);
    expBus  = (k == LAT) ? mQ : (k == LAT + 1) ? mR : '0;
    check("cycle done", done, expDone);
    check("cycle outBus", outBus, expBus);
  end

  // One operation; called with the DUT idle. Returns quotient, remainder and the
  // cycle (relative to the start-sample cycle 0) in which done first appeared.
  task automatic doOp(input logic [W-1:0] x, input logic [W-1:0] m, input bit keepStart,
                      input int pulseAt, output logic [W-1:0] q, output logic [W-1:0] r,
                      output int lat);
    @(negedge clk); start = 1'b1;      inBus = '0;
    @(negedge clk); start = keepStart; inBus = x;
    @(negedge clk); inBus = m;
    @(negedge clk);
    lat   = 3;
    start = keepStart || (pulseAt == lat);
    inBus = W'($urandom);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      start = keepStart || (lat == pulseAt);
      inBus = W'($urandom);
    end
    if (done !== 1'b1) begin
      check("done timeout", 0, 1);
      q = '0;
      r = '0;
    end else begin
      q = outBus;
      @(negedge clk);
      start = keepStart;
      r = outBus;
    end
  endtask

  initial begin
    logic [W-1:0] q, r;
    int           lat;
    int           doneSeen;

    rst = 1'b1; start = 1'b0; inBus = '0;
    repeat (2) @(negedge clk);
    check("reset done", done, 0);
    check("reset outBus", outBus, 0);
    rst = 1'b0;

    doOp(6'd45, 6'd6, 1'b0, -1, q, r, lat);
    check("45/6 q", q, 7); check("45/6 r", r, 3); check("45/6 latency", lat, 9);

    doOp(6'd63, 6'd1, 1'b0, -1, q, r, lat);
    check("63/1 q", q, 63); check("63/1 r", r, 0);
    doOp(6'd63, 6'd63, 1'b0, -1, q, r, lat);
    check("63/63 q", q, 1); check("63/63 r", r, 0);

    doOp(6'd5, 6'd9, 1'b0, -1, q, r, lat);
    check("5/9 q", q, 0); check("5/9 r", r, 5);

    doOp(6'd17, 6'd0, 1'b0, -1, q, r, lat);
    check("17/0 q", q, 63); check("17/0 r", r, 17); check("17/0 latency", lat, 9);

    // Reset in cycle 5 of an operation, i.e. mid-CALC.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; inBus = 6'd50;
    @(negedge clk); inBus = 6'd7;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-calc reset done", done, 0);
    check("mid-calc reset outBus", outBus, 0);
    rst = 1'b0;
    doOp(6'd20, 6'd4, 1'b0, -1, q, r, lat);
    check("20/4 q", q, 5); check("20/4 r", r, 0); check("20/4 latency", lat, 9);

    // start pulsed during CALC must not launch another operation.
    doOp(6'd40, 6'd3, 1'b0, 5, q, r, lat);
    check("40/3 q", q, 13); check("40/3 r", r, 1);
    doneSeen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    check("pulsed start ignored", doneSeen, 0);

    // start held high: back-to-back operations.
    doOp(6'd59, 6'd8, 1'b1, -1, q, r, lat);
    check("59/8 q", q, 7); check("59/8 r", r, 3); check("59/8 latency", lat, 9);
    doOp(6'd33, 6'd5, 1'b1, -1, q, r, lat);
    check("33/5 q", q, 6); check("33/5 r", r, 3); check("33/5 latency", lat, 9);
    doOp(6'd62, 6'd7, 1'b1, -1, q, r, lat);
    check("62/7 q", q, 8); check("62/7 r", r, 6); check("62/7 latency", lat, 9);

    // Full sweep of all operand pairs, back-to-back.
    for (int x = 0; x < 64; x++) begin
      for (int m = 0; m < 64; m++) begin
        doOp(W'(x), W'(m), 1'b1, -1, q, r, lat);
        if (m == 0) begin
          check("sweep div0 q", q, 63);
          check("sweep div0 r", r, x);
        end else begin
          check("sweep q*m+r", int'(q) * m + int'(r), x);
          check("sweep r<m", int'(r) < m, 1);
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
